ipg_tx_arbiter: RTL and testbench
=================================

Name: ipg_tx_arbiter

Overview:
- Shares the transmit IPG side-channel between two chunk sources: src0 is the memory-reply chunk queue (highest-priority traffic), src1 is the outgoing request chunk queue.
- Each IPG slot offered by the PCS TX path carries at most one chunk.
- Arbitration is message-atomic. Once a source wins, only that source is served until its last chunk is sent, so the far-end receive state machine never sees two messages interleaved.
- Round-robin between sources at message boundaries, plus a stall watchdog on the locked owner.

Parameters:
- CHUNK_W, 64, chunk width in bits: bits [7:0] are the block type, bits [63:8] are payload.
- LEN_W, 6, width of the payload-length fields.
- STALL_MAX, 16, number of consecutive slots the locked owner may leave unused before the lock is force-released.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- src0_data  in  64  head chunk of src0 (first-word-fall-through)
- src0_len  in  6  payload bits used in the head chunk, 1..56
- src0_last  in  1  head chunk is the last chunk of its message
- src0_valid  in  1  src0 head is valid
- src0_pop  out  1  pops the src0 head; combinational
- src1_data, src1_len, src1_last, src1_valid, src1_pop  as for src0
- slot_valid  in  1  PCS has an idle block available for IPG data in this cycle
- slot_len  in  6  payload bits the slot can carry, 0..56
- tx_ipg_data  out  64  chunk driven to the PCS, registered
- tx_len  out  6  payload bits valid in tx_ipg_data; 0 means no data
- tx_valid  out  1  tx_ipg_data/tx_len are valid, registered
- owner  out  1  current lock owner (meaningful only while locked)
- locked  out  1  a message is in progress
- err_stall  out  1  one-cycle pulse when the watchdog releases the lock

Behaviour:
- Reset (rst=1 at a clock edge):
  - tx_ipg_data=0, tx_len=0, tx_valid=0, err_stall=0, locked=0, owner=0.
  - rr_ptr=0 (src0 preferred first); stall counter=0.
  - src*_pop is 0 while rst=1.
  - A reset mid-message drops the lock. Sources are not popped further; flushing them is the source's responsibility.
- State machine: IDLE (locked=0) and LOCK (locked=1, owner fixed).
- Eligibility: source N is eligible in cycle T iff slot_valid & srcN_valid & (srcN_len <= slot_len).
- IDLE, cycle T:
  - If one source is eligible, it is granted.
  - If both are eligible, the source equal to rr_ptr is granted.
  - If none is eligible, nothing happens.
  - On a grant with last=0: go to LOCK with owner=N.
  - On a grant with last=1 (single-chunk message): stay in IDLE.
  - On every grant, rr_ptr becomes ~N when the message completes.
- LOCK, cycle T:
  - Only the owner may be granted; the other source is never granted, even if it is eligible.
  - Owner granted with last=1: return to IDLE, rr_ptr=~owner, stall counter cleared.
  - Owner granted with last=0: stay in LOCK, stall counter cleared.
  - slot_valid=1 but the owner is not eligible: the slot is wasted and the stall counter increments.
  - When the counter would reach STALL_MAX: go to IDLE, rr_ptr=~owner, pulse err_stall at T+1, counter cleared.
  - Cycles with slot_valid=0 do not count toward the watchdog.
- Grant in cycle T:
  - srcN_pop=1 in cycle T (combinational), exactly one pop per grant, never two pops in one cycle.
  - At T+1: tx_ipg_data = srcN_data with bits [7:0] forced to 8'h1e, tx_len=srcN_len, tx_valid=1.
  - Back-to-back slot_valid is supported, giving one chunk per cycle.
- No grant in cycle T: tx_valid=0 and tx_len=0 at T+1. tx_ipg_data holds its previous value.
- slot_len=0, or slot_len less than the head's len: no grant. The chunk is never split across slots.

Test Plan:
- After reset, src0 single chunk (len=56, last=1) with slot_valid every cycle -> src0_pop in the first cycle, next cycle tx_valid=1, tx_len=56, tx_ipg_data[7:0]=8'h1e; locked stays 0.
- src0 and src1 both valid with 3-chunk messages, continuous slots -> tx order is src0 c0, c1, c2 then src1 c0, c1, c2; src1_pop stays 0 during the src0 lock; locked=1 for the middle chunks.
- Both sources continuously offering single-chunk messages -> grants alternate 0, 1, 0, 1; no source is granted twice in a row.
- slot_len=40 with src0 head len=56 -> no pop and tx_valid=0. Next slot with slot_len=56 -> chunk is sent.
- src1 locked after chunk 0, then src1_valid=0 for 16 slot_valid cycles while src0 is valid -> err_stall pulses once, locked=0, src0 is granted on the next slot.
- rst asserted in the middle of a src0 message -> all outputs return to their reset values next cycle; a subsequent src1 message is granted from IDLE.

Source files
------------

// File: rtl/ipg_tx_arbiter_if.sv
// rtl/ipg_tx_arbiter_if.sv - chunk sources, PCS slot offer and IPG transmit signals of the arbiter
interface ipg_tx_arbiter_if #(
  parameter int CHUNK_W = 64,
  parameter int LEN_W   = 6
);
  logic [CHUNK_W-1:0] src0_data;
  logic [LEN_W-1:0]   src0_len;
  logic               src0_last;
  logic               src0_valid;
  logic               src0_pop;

  logic [CHUNK_W-1:0] src1_data;
  logic [LEN_W-1:0]   src1_len;
  logic               src1_last;
  logic               src1_valid;
  logic               src1_pop;

  logic               slot_valid;
  logic [LEN_W-1:0]   slot_len;

  logic [CHUNK_W-1:0] tx_ipg_data;
  logic [LEN_W-1:0]   tx_len;
  logic               tx_valid;
  logic               owner;
  logic               locked;
  logic               err_stall;

  modport master (
    output src0_data, src0_len, src0_last, src0_valid,
    output src1_data, src1_len, src1_last, src1_valid,
    output slot_valid, slot_len,
    input  src0_pop, src1_pop,
    input  tx_ipg_data, tx_len, tx_valid, owner, locked, err_stall
  );

  modport slave (
    input  src0_data, src0_len, src0_last, src0_valid,
    input  src1_data, src1_len, src1_last, src1_valid,
    input  slot_valid, slot_len,
    output src0_pop, src1_pop,
    output tx_ipg_data, tx_len, tx_valid, owner, locked, err_stall
  );
endinterface

// File: rtl/ipg_tx_arbiter.sv
// rtl/ipg_tx_arbiter.sv - message-atomic round-robin arbiter of two chunk queues onto IPG slots
module ipg_tx_arbiter #(
  parameter int CHUNK_W   = 64,
  parameter int LEN_W     = 6,
  parameter int STALL_MAX = 16
) (
  input  logic            clk,
  input  logic            rst,
  ipg_tx_arbiter_if.slave bus
);

  typedef enum logic {ST_IDLE, ST_LOCK} state_t;

  localparam int CNT_W = $clog2(STALL_MAX + 1);
  localparam logic [CHUNK_W-1:0] TYPE_MASK  = {{(CHUNK_W-8){1'b0}}, 8'hff};
  localparam logic [CHUNK_W-1:0] BLOCK_TYPE = {{(CHUNK_W-8){1'b0}}, 8'h1e};

  state_t             state;
  state_t             state_nxt;
  logic               owner_q;
  logic               owner_nxt;
  logic               rr_q;
  logic               rr_nxt;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               stall_rel;

  logic               elig0;
  logic               elig1;
  logic               grant0;
  logic               grant1;
  logic               sel;
  logic               sel_last;
  logic [LEN_W-1:0]   sel_len;
  logic [CHUNK_W-1:0] sel_data;

  logic [CHUNK_W-1:0] tx_data_q;
  logic [LEN_W-1:0]   tx_len_q;
  logic               tx_valid_q;
  logic               err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state   <= state_nxt;
      owner_q <= owner_nxt;
      rr_q    <= rr_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  always_comb begin
    elig0     = bus.slot_valid & bus.src0_valid & (bus.src0_len <= bus.slot_len);
    elig1     = bus.slot_valid & bus.src1_valid & (bus.src1_len <= bus.slot_len);
    grant0    = 1'b0;
    grant1    = 1'b0;
    state_nxt = state;
    owner_nxt = owner_q;
    rr_nxt    = rr_q;
    cnt_nxt   = cnt_q;
    stall_rel = 1'b0;

    case (state)
      ST_IDLE: begin
        if (elig0 && elig1) begin
          grant0 = ~rr_q;
          grant1 = rr_q;
        end else begin
          grant0 = elig0;
          grant1 = elig1;
        end
      end
      ST_LOCK: begin
        grant0 = elig0 & ~owner_q;
        grant1 = elig1 & owner_q;
        // Only offered slots the owner could not use count toward the watchdog.
        if (bus.slot_valid && !grant0 && !grant1) begin
          if (cnt_q == CNT_W'(STALL_MAX - 1)) begin
            stall_rel = 1'b1;
            state_nxt = ST_IDLE;
            rr_nxt    = ~owner_q;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    sel      = grant1;
    sel_last = sel ? bus.src1_last : bus.src0_last;
    sel_len  = sel ? bus.src1_len  : bus.src0_len;
    sel_data = sel ? bus.src1_data : bus.src0_data;

    if (grant0 || grant1) begin
      cnt_nxt = '0;
      if (sel_last) begin
        state_nxt = ST_IDLE;
        rr_nxt    = ~sel;
      end else begin
        state_nxt = ST_LOCK;
        owner_nxt = sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data_q  <= '0;
      tx_len_q   <= '0;
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= stall_rel;
      if (grant0 || grant1) begin
        tx_data_q  <= (sel_data & ~TYPE_MASK) | BLOCK_TYPE;
        tx_len_q   <= sel_len;
        tx_valid_q <= 1'b1;
      end else begin
        tx_len_q   <= '0;
        tx_valid_q <= 1'b0;
      end
    end
  end

  assign bus.src0_pop    = grant0 & ~rst;
  assign bus.src1_pop    = grant1 & ~rst;
  assign bus.tx_ipg_data = tx_data_q;
  assign bus.tx_len      = tx_len_q;
  assign bus.tx_valid    = tx_valid_q;
  assign bus.owner       = owner_q;
  assign bus.locked      = (state == ST_LOCK);
  assign bus.err_stall   = err_q;

endmodule

// File: tb/tb_ipg_tx_arbiter.sv
// tb/tb_ipg_tx_arbiter.sv - vector table, corner sequences and randomized model check of ipg_tx_arbiter
module tb_ipg_tx_arbiter;
  localparam int STALL_MAX = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ipg_tx_arbiter_if #(.CHUNK_W(64), .LEN_W(6)) bus ();

  ipg_tx_arbiter #(.CHUNK_W(64), .LEN_W(6), .STALL_MAX(STALL_MAX)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    logic       rst;
    logic       v0;
    logic [5:0] l0;
    logic       last0;
    logic       v1;
    logic [5:0] l1;
    logic       last1;
    logic       sv;
    logic [5:0] sl;
    logic       e_pop0;
    logic       e_pop1;
    logic       e_txv;
    logic [5:0] e_txlen;
    logic       e_locked;
  } vec_t;

  int total = 0;
  int bad   = 0;
  logic [63:0] cur_d0;
  logic [63:0] cur_d1;
  vec_t tbl[19];

  function automatic vec_t mk(input logic r, input logic v0, input int l0, input logic la0,
                              input logic v1, input int l1, input logic la1,
                              input logic sv, input int sl, input logic p0, input logic p1,
                              input logic txv, input int txl, input logic lk);
    vec_t t;
    t.rst = r; t.v0 = v0; t.l0 = 6'(l0); t.last0 = la0;
    t.v1 = v1; t.l1 = 6'(l1); t.last1 = la1;
    t.sv = sv; t.sl = 6'(sl); t.e_pop0 = p0; t.e_pop1 = p1;
    t.e_txv = txv; t.e_txlen = 6'(txl); t.e_locked = lk;
    return t;
  endfunction

  function automatic logic [63:0] stamp(input logic [63:0] d);
    return {d[63:8], 8'h1e};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input int l0, input logic la0,
                       input logic v1, input int l1, input logic la1,
                       input logic sv, input int sl);
    cur_d0 = {$urandom, $urandom};
    cur_d1 = {$urandom, $urandom};
    bus.src0_data = cur_d0; bus.src0_len = 6'(l0); bus.src0_last = la0; bus.src0_valid = v0;
    bus.src1_data = cur_d1; bus.src1_len = 6'(l1); bus.src1_last = la1; bus.src1_valid = v1;
    bus.slot_valid = sv; bus.slot_len = 6'(sl);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Rule-level reference state: owner index or -1, round-robin preference, wasted-slot run.
  int m_own;
  int m_rr;
  int m_stall;
  logic [63:0] m_data;

  initial begin
    int w;
    drive(0, 1, 0, 0, 1, 0, 0, 0);
    rst = 1'b1;
    tick();
    tick();
    chk("reset_tx_valid", bus.tx_valid, 0);
    chk("reset_tx_len", bus.tx_len, 0);
    chk("reset_tx_data", bus.tx_ipg_data, 0);
    chk("reset_locked", bus.locked, 0);
    chk("reset_owner", bus.owner, 0);
    chk("reset_err", bus.err_stall, 0);

    tbl[0]  = mk(1, 1,56,1, 0, 1,0, 1,56, 0,0, 0, 0,0);
    tbl[1]  = mk(0, 1,56,1, 0, 1,0, 1,56, 1,0, 1,56,0);
    tbl[2]  = mk(0, 1,56,1, 0, 1,0, 1,40, 0,0, 0, 0,0);
    tbl[3]  = mk(0, 1,56,1, 0, 1,0, 1,56, 1,0, 1,56,0);
    tbl[4]  = mk(0, 0, 5,1, 1,10,1, 1,56, 0,1, 1,10,0);
    tbl[5]  = mk(0, 1,20,0, 1,30,0, 1,56, 1,0, 1,20,1);
    tbl[6]  = mk(0, 1,21,0, 1,30,0, 1,56, 1,0, 1,21,1);
    tbl[7]  = mk(0, 1,22,1, 1,30,0, 1,56, 1,0, 1,22,0);
    tbl[8]  = mk(0, 1, 5,1, 1,30,0, 1,56, 0,1, 1,30,1);
    tbl[9]  = mk(0, 1, 5,1, 1,50,0, 1,40, 0,0, 0, 0,1);
    tbl[10] = mk(0, 1, 5,1, 1,31,0, 1,56, 0,1, 1,31,1);
    tbl[11] = mk(0, 1, 5,1, 1,32,1, 1,56, 0,1, 1,32,0);
    tbl[12] = mk(0, 1, 5,1, 1, 6,1, 0,56, 0,0, 0, 0,0);
    tbl[13] = mk(0, 1, 8,1, 1, 9,1, 1,56, 1,0, 1, 8,0);
    tbl[14] = mk(0, 1, 8,1, 1, 9,1, 1,56, 0,1, 1, 9,0);
    tbl[15] = mk(0, 1, 8,1, 1, 9,1, 1,56, 1,0, 1, 8,0);
    tbl[16] = mk(0, 1, 8,1, 1, 9,1, 1,56, 0,1, 1, 9,0);
    tbl[17] = mk(0, 1, 1,1, 1, 1,1, 1, 0, 0,0, 0, 0,0);
    tbl[18] = mk(0, 1, 1,1, 1, 1,1, 1, 1, 1,0, 1, 1,0);

    for (int i = 0; i < 19; i++) begin
      rst = tbl[i].rst;
      drive(tbl[i].v0, tbl[i].l0, tbl[i].last0, tbl[i].v1, tbl[i].l1, tbl[i].last1,
            tbl[i].sv, tbl[i].sl);
      #1;
      chk($sformatf("vec%0d_pop0", i), bus.src0_pop, tbl[i].e_pop0);
      chk($sformatf("vec%0d_pop1", i), bus.src1_pop, tbl[i].e_pop1);
      tick();
      chk($sformatf("vec%0d_tx_valid", i), bus.tx_valid, tbl[i].e_txv);
      chk($sformatf("vec%0d_tx_len", i), bus.tx_len, tbl[i].e_txlen);
      chk($sformatf("vec%0d_locked", i), bus.locked, tbl[i].e_locked);
      if (tbl[i].e_txv)
        chk($sformatf("vec%0d_tx_data", i), bus.tx_ipg_data,
            stamp(tbl[i].e_pop0 ? cur_d0 : cur_d1));
    end

    // Watchdog: src1 locks, then starves for STALL_MAX offered slots (one idle cycle interleaved).
    rst = 1'b1;
    drive(0, 1, 0, 0, 1, 0, 0, 0);
    tick();
    rst = 1'b0;
    drive(0, 10, 1, 1, 10, 0, 1, 56);
    #1;
    chk("stall_lock_pop1", bus.src1_pop, 1);
    tick();
    chk("stall_locked", bus.locked, 1);
    chk("stall_owner", bus.owner, 1);
    w = 0;
    for (int k = 0; k < STALL_MAX + 1; k++) begin
      drive(1, 10, 1, 0, 10, 0, (k != 5), 56);
      #1;
      chk("stall_pop0", bus.src0_pop, 0);
      chk("stall_pop1", bus.src1_pop, 0);
      tick();
      if (k != 5) w++;
      chk("stall_locked_run", bus.locked, (w < STALL_MAX));
      chk("stall_err_run", bus.err_stall, (w == STALL_MAX));
    end
    drive(1, 10, 1, 0, 10, 0, 1, 56);
    #1;
    chk("after_stall_pop0", bus.src0_pop, 1);
    tick();
    chk("after_stall_err", bus.err_stall, 0);
    chk("after_stall_tx_valid", bus.tx_valid, 1);
    chk("after_stall_tx_len", bus.tx_len, 10);
    chk("after_stall_locked", bus.locked, 0);

    // Reset in the middle of a src0 message.
    drive(1, 12, 0, 0, 1, 0, 1, 56);
    #1;
    chk("midrst_pop0", bus.src0_pop, 1);
    tick();
    chk("midrst_locked", bus.locked, 1);
    rst = 1'b1;
    drive(1, 12, 0, 0, 1, 0, 1, 56);
    #1;
    chk("midrst_pop0_in_rst", bus.src0_pop, 0);
    tick();
    chk("midrst_tx_valid", bus.tx_valid, 0);
    chk("midrst_tx_len", bus.tx_len, 0);
    chk("midrst_tx_data", bus.tx_ipg_data, 0);
    chk("midrst_locked", bus.locked, 0);
    chk("midrst_owner", bus.owner, 0);
    chk("midrst_err", bus.err_stall, 0);
    rst = 1'b0;
    drive(0, 12, 0, 1, 9, 1, 1, 56);
    #1;
    chk("postrst_pop1", bus.src1_pop, 1);
    tick();
    chk("postrst_tx_valid", bus.tx_valid, 1);
    chk("postrst_tx_len", bus.tx_len, 9);
    chk("postrst_locked", bus.locked, 0);

    // Randomized traffic against the reference model.
    rst = 1'b1;
    drive(0, 1, 0, 0, 1, 0, 0, 0);
    tick();
    rst = 1'b0;
    m_own = -1; m_rr = 0; m_stall = 0; m_data = '0;
    for (int b = 0; b < 8; b++) begin
      int vp;
      vp = (b % 2 == 0) ? 85 : 15;
      for (int c = 0; c < 250; c++) begin
        logic v0, v1, la0, la1, sv, e0, e1, rel, glast;
        int l0, l1, sl, g, glen;
        v0 = ($urandom_range(0, 99) < vp);
        v1 = ($urandom_range(0, 99) < vp);
        la0 = ($urandom_range(0, 9) < 3);
        la1 = ($urandom_range(0, 9) < 3);
        l0 = $urandom_range(1, 56);
        l1 = $urandom_range(1, 56);
        sv = ($urandom_range(0, 3) != 0);
        sl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 56) : 56;
        drive(v0, l0, la0, v1, l1, la1, sv, sl);
        #1;
        e0 = sv && v0 && (l0 <= sl);
        e1 = sv && v1 && (l1 <= sl);
        g = -1;
        rel = 1'b0;
        if (m_own < 0) begin
          if (e0 && e1) g = m_rr;
          else if (e0) g = 0;
          else if (e1) g = 1;
        end else if ((m_own == 0 && e0) || (m_own == 1 && e1)) begin
          g = m_own;
        end else if (sv) begin
          m_stall++;
          if (m_stall == STALL_MAX) begin
            rel = 1'b1;
            m_rr = 1 - m_own;
            m_own = -1;
            m_stall = 0;
          end
        end
        glen = 0;
        if (g >= 0) begin
          glast = (g == 1) ? la1 : la0;
          glen = (g == 1) ? l1 : l0;
          m_data = stamp((g == 1) ? cur_d1 : cur_d0);
          m_stall = 0;
          if (glast) begin
            m_own = -1;
            m_rr = 1 - g;
          end else begin
            m_own = g;
          end
        end
        chk("rnd_pop0", bus.src0_pop, (g == 0));
        chk("rnd_pop1", bus.src1_pop, (g == 1));
        tick();
        chk("rnd_tx_valid", bus.tx_valid, (g >= 0));
        chk("rnd_tx_len", bus.tx_len, 64'(glen));
        chk("rnd_tx_data", bus.tx_ipg_data, m_data);
        chk("rnd_locked", bus.locked, (m_own >= 0));
        chk("rnd_err", bus.err_stall, rel);
        if (m_own >= 0)
          chk("rnd_owner", bus.owner, 64'(m_own));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
